// File: rtl/fp_mul_pkg.sv
// Shared types, constants and helpers for the sequential floating-point multiplier.
// Widths are passed in because the package itself is not parameterised.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_t;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN with only the top fraction bit set, positive sign.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] one;
    one = 64'd1;
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

  // Exponent field zero is flushed to zero regardless of fraction.
  function automatic fp_class_t fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_mant_seq_mul.sv
// Iterative shift-add significand multiplier, one multiplier bit per cycle, LSB first.
// start loads operands; done is high during the last iteration cycle, product valid after that edge.
module fp_mant_seq_mul #(
  parameter int M = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   mcand,
  input  logic [M-1:0]   mplier,
  output logic           done,
  output logic [2*M-1:0] product
);

  localparam int CW = $clog2(M + 1);

  logic [CW-1:0]  cnt;
  logic           busy;
  logic [M-1:0]   mcand_q;
  logic [2*M-1:0] acc;
  logic [M:0]     sum;

  // Upper half accumulates; the multiplier shifts out of the lower half as product bits shift in.
  assign sum     = {1'b0, acc[2*M-1:M]} + {1'b0, (acc[0] ? mcand_q : {M{1'b0}})};
  assign done    = busy && (cnt == CW'(M - 1));
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      busy    <= 1'b0;
      mcand_q <= '0;
      acc     <= '0;
    end else if (start) begin
      cnt     <= '0;
      busy    <= 1'b1;
      mcand_q <= mcand;
      acc     <= {{M{1'b0}}, mplier};
    end else if (busy) begin
      acc <= {sum, acc[M-1:1]};
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754-style multiplier; MAN_W+3 edges normal path, 2 edges for specials.
// One op in flight: in_ready only in IDLE, result held until out_ready. FP_MUL_RNE_EN selects RNE over truncation.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int M  = MAN_W + 1;
  localparam int PW = 2 * M;
  localparam int E2 = EXP_W + 2;

  localparam logic signed [E2-1:0] BIAS_E    = E2'(fp_bias(EXP_W));
  localparam logic signed [E2-1:0] EXP_MAX   = E2'((1 << EXP_W) - 1);
  localparam logic signed [E2-1:0] EXP_ZERO  = '0;
  localparam logic [63:0]          NAN64     = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]         CANON_NAN = NAN64[W-1:0];

  state_t state_q, state_d;

  logic             a_sign, b_sign, sgn;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  fp_class_t        a_cls, b_cls;

  assign {a_sign, a_exp, a_frac} = a;
  assign {b_sign, b_exp, b_frac} = b;
  assign sgn   = a_sign ^ b_sign;
  assign a_cls = fp_classify(a_exp == '0, &a_exp, a_frac == '0);
  assign b_cls = fp_classify(b_exp == '0, &b_exp, b_frac == '0);

  logic signed [E2-1:0] exp_sum;
  assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_E;

  logic         is_special;
  logic [W-1:0] spec_res;
  logic [2:0]   spec_flags;

  always_comb begin
    is_special = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_cls == CLS_NAN || b_cls == CLS_NAN) begin
      spec_res = CANON_NAN;
    end else if ((a_cls == CLS_INF && b_cls == CLS_ZERO) ||
                 (b_cls == CLS_INF && a_cls == CLS_ZERO)) begin
      spec_res                 = CANON_NAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_cls == CLS_INF || b_cls == CLS_INF) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_cls == CLS_ZERO || b_cls == CLS_ZERO) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  logic          accept, mul_start, mul_done;
  logic [PW-1:0] prod;

  fp_mant_seq_mul #(.M(M)) u_mant (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   ({1'b1, a_frac}),
    .mplier  ({1'b1, b_frac}),
    .done    (mul_done),
    .product (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Specials skip the multiplier and pass through NORM so they leave one edge after capture.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        accept    = 1'b1;
        mul_start = !is_special;
        state_d   = is_special ? ST_NORM : ST_MUL;
      end
      ST_MUL:  if (mul_done) state_d = ST_NORM;
      ST_NORM: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  logic                 sign_q, special_q;
  logic signed [E2-1:0] exp_q;
  logic [W-1:0]         result_q;
  logic [2:0]           flags_q;

  logic                 prod_msb;
  logic [PW-1:0]        prod_n;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic [MAN_W:0]       frac_sum;
  logic                 round_up, carry, unused_bits;
  logic signed [E2-1:0] exp_n, exp_f;

  assign prod_msb = prod[PW-1];
  assign prod_n   = prod_msb ? prod : {prod[PW-2:0], 1'b0};
  assign frac_t   = prod_n[PW-2 -: MAN_W];
  assign exp_n    = exp_q + $signed({{(E2-1){1'b0}}, prod_msb});

`ifdef FP_MUL_RNE_EN
  logic guard, sticky;
  assign guard       = prod_n[MAN_W];
  assign sticky      = |prod_n[MAN_W-1:0];
  assign round_up    = guard & (sticky | frac_t[0]);
  assign unused_bits = prod_n[PW-1];
`else
  assign round_up    = 1'b0;
  assign unused_bits = ^{prod_n[PW-1], prod_n[MAN_W:0]};
`endif

  // A rounding carry leaves frac_r at zero, which is the renormalised fraction.
  assign frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
  assign carry    = frac_sum[MAN_W];
  assign frac_r   = frac_sum[MAN_W-1:0];
  assign exp_f    = exp_n + $signed({{(E2-1){1'b0}}, carry});

  logic [W-1:0] norm_res;
  logic [2:0]   norm_flags;

  always_comb begin
    norm_res   = {sign_q, exp_f[EXP_W-1:0], frac_r};
    norm_flags = '0;
    if (exp_f >= EXP_MAX) begin
      norm_res                  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      norm_res                   = {sign_q, {(W-1){1'b0}}};
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      exp_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (accept) begin
      sign_q    <= sgn;
      special_q <= is_special;
      exp_q     <= exp_sum;
      result_q  <= spec_res;
      flags_q   <= spec_flags;
    end else if (state_q == ST_NORM && !special_q) begin
      result_q <= norm_res;
      flags_q  <= norm_flags;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule
